fp_result_scheduler: RTL

- Shares the single 32-bit parallel-in/serial-out result register between two FP adder result channels.
- Round-robin arbitration picks a channel; the block writes the winner's word into the output register, then streams 32 bits out LSB-first.
- Waits for the register to report it is free again before the next grant.
- Sits between the adder result interfaces and the output register, which it drives through that register's wr/read/ready handshake.

---
 rtl/fp_result_scheduler_if.sv | 37 +++
 rtl/fp_result_scheduler.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/fp_result_scheduler_if.sv
// Handshake bundle between the two FP adder result channels, the output
// shift register and the result scheduler.
interface fp_result_scheduler_if #(
    parameter int WORD_W = 32
);
    logic              res0_valid_in;
    logic [WORD_W-1:0] res0_data_in;
    logic              res0_ack_out;
    logic              res1_valid_in;
    logic [WORD_W-1:0] res1_data_in;
    logic              res1_ack_out;
    logic              stream_en_in;
    logic              reg_input_rdy_in;
    logic              reg_output_rdy_in;
    logic [WORD_W-1:0] reg_par_out;
    logic              reg_wr_out;
    logic              reg_read_out;
    logic              bit_valid_out;
    logic              grant_out;
    logic              busy_out;

    // Scheduler side
    modport master (
        input  res0_valid_in, res0_data_in, res1_valid_in, res1_data_in,
        input  stream_en_in, reg_input_rdy_in, reg_output_rdy_in,
        output res0_ack_out, res1_ack_out, reg_par_out, reg_wr_out,
        output reg_read_out, bit_valid_out, grant_out, busy_out
    );

    // Requesters and output register side
    modport slave (
        output res0_valid_in, res0_data_in, res1_valid_in, res1_data_in,
        output stream_en_in, reg_input_rdy_in, reg_output_rdy_in,
        input  res0_ack_out, res1_ack_out, reg_par_out, reg_wr_out,
        input  reg_read_out, bit_valid_out, grant_out, busy_out
    );
endinterface

// File: rtl/fp_result_scheduler.sv
// Round-robin scheduler sharing one parallel-in/serial-out result register
// between two FP adder result channels; each word is written then drained LSB-first.
module fp_result_scheduler #(
    parameter int WORD_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    fp_result_scheduler_if.master bus
);
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WRITE    = 2'd1,
        DRAIN    = 2'd2,
        WAIT_RLS = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] WORD_CNT = CNT_W'(WORD_W);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              last_grant_q, last_grant_d;
    logic [WORD_W-1:0] par_q, par_d;
    logic              wr_q, wr_d;
    logic              ack0_q, ack0_d;
    logic              ack1_q, ack1_d;
    logic              grant_q, grant_d;
    logic              bit_valid_q, bit_valid_d;
    logic              busy_q, busy_d;
    logic              sel_s;
    logic              read_s;

    // Channel choice: a lone requester wins, a tie goes to the channel not served last
    always_comb begin
        if (bus.res0_valid_in && bus.res1_valid_in) begin
            sel_s = ~last_grant_q;
        end else if (bus.res1_valid_in) begin
            sel_s = 1'b1;
        end else begin
            sel_s = 1'b0;
        end
    end

    // Serial read strobe is driven straight from registered state and live flow control
    always_comb begin
        read_s = (state_q == DRAIN) && bus.stream_en_in && bus.reg_output_rdy_in &&
                 (bit_cnt_q < WORD_CNT);
    end

    // Next-state and next-output computation
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        last_grant_d = last_grant_q;
        par_d        = par_q;
        wr_d         = 1'b0;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        grant_d      = grant_q;
        case (state_q)
            IDLE: begin
                if (bus.reg_input_rdy_in && (bus.res0_valid_in || bus.res1_valid_in)) begin
                    state_d      = WRITE;
                    par_d        = sel_s ? bus.res1_data_in : bus.res0_data_in;
                    wr_d         = 1'b1;
                    ack0_d       = ~sel_s;
                    ack1_d       = sel_s;
                    grant_d      = sel_s;
                    last_grant_d = sel_s;
                end else begin
                    state_d = IDLE;
                end
            end
            WRITE: begin
                state_d   = DRAIN;
                bit_cnt_d = {CNT_W{1'b0}};
            end
            DRAIN: begin
                if (read_s) begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == (WORD_CNT - CNT_W'(1))) begin
                        state_d = WAIT_RLS;
                    end else begin
                        state_d = DRAIN;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q;
                end
            end
            WAIT_RLS: begin
                if (bus.reg_input_rdy_in) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT_RLS;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d      = (state_d != IDLE);
        bit_valid_d = read_s;
    end

    // State and registered outputs; reset drops any word in flight without re-acking
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q      <= IDLE;
            bit_cnt_q    <= {CNT_W{1'b0}};
            last_grant_q <= 1'b1;
            par_q        <= {WORD_W{1'b0}};
            wr_q         <= 1'b0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            grant_q      <= 1'b0;
            bit_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            last_grant_q <= last_grant_d;
            par_q        <= par_d;
            wr_q         <= wr_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            grant_q      <= grant_d;
            bit_valid_q  <= bit_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.res0_ack_out  = ack0_q;
    assign bus.res1_ack_out  = ack1_q;
    assign bus.reg_par_out   = par_q;
    assign bus.reg_wr_out    = wr_q;
    assign bus.reg_read_out  = read_s;
    assign bus.bit_valid_out = bit_valid_q;
    assign bus.grant_out     = grant_q;
    assign bus.busy_out      = busy_q;
endmodule
